cam_sched: RTL and testbench
============================

# cam_sched

Lookup scheduler and configuration sequencer for the 16-entry CAM lookup pipeline. It shares the CAM's single lookup port among NREQ requesters with round-robin arbitration. Each lookup carries a requester tag through a shift pipe that matches the CAM's fixed latency, so every result returns to the requester that issued it. It also serialises entry writes: lookups are drained before a write so no in-flight lookup sees a half-updated table.

## Interface
- NREQ, 4: number of lookup requesters (2..8)
- KEY_W, 4: key / entry width
- IDX_W, 4: CAM index width (16 entries)
- CAM_LAT, 3: CAM latency, cam_req_vld to cam_rsp_vld, in cycles
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_vld  in  NREQ  per-requester lookup valid
- req_key  in  NREQ*KEY_W  packed keys; requester i uses bits [i*KEY_W +: KEY_W]
- req_rdy  out  NREQ  one-hot grant; a lookup is accepted when req_vld[i] & req_rdy[i]
- rsp_vld  out  NREQ  one-hot result strobe
- rsp_idx  out  IDX_W  matched index, shared by all requesters
- cfg_wr_vld  in  1  entry write request
- cfg_wr_addr  in  IDX_W  entry to write
- cfg_wr_data  in  KEY_W  new entry value
- cfg_wr_rdy  out  1  one-cycle pulse; the write is committed in that cycle
- cam_req_vld  out  1  lookup issue to the CAM (registered)
- cam_req_key  out  KEY_W  lookup key (registered)
- cam_rsp_vld  in  1  CAM result valid
- cam_rsp_idx  in  IDX_W  CAM result index
- cam_wr_en  out  1  CAM entry write strobe
- cam_wr_addr  out  IDX_W  CAM write address
- cam_wr_data  out  KEY_W  CAM write data
- stat_sel  in  3  statistics requester select (present only with CAM_SCHED_STATS_EN)
- stat_cnt  out  16  grant count of requester stat_sel (present only with CAM_SCHED_STATS_EN)

## Operation
- The FSM has three states: RUN, DRAIN and WRITE. Reset state is RUN.
- **RUN**
  - req_rdy is the round-robin grant over req_vld: search starts at last_grant+1 and wraps. Reset value of last_grant is NREQ-1, so requester 0 wins first.
  - At most one grant per cycle; req_rdy is zero when no req_vld is set.
  - last_grant updates only on an accepted lookup.
  - If cfg_wr_vld=1, no grant is issued this cycle and the FSM goes to DRAIN. A write request beats lookups in the same cycle.
- **DRAIN**
  - req_rdy=0.
  - busy = cam_req_vld | any tag-pipe valid bit.
  - When busy=0, go to WRITE.
- **WRITE**
  - cam_wr_en=1, cam_wr_addr/cam_wr_data taken from cfg_wr_*, cfg_wr_rdy=1, req_rdy=0.
  - Next state is RUN unconditionally.
- **Tag pipe**
  - CAM_LAT stages of {valid, requester id}, loaded in step with cam_req_vld.
  - rsp_vld[id] = cam_rsp_vld & stage[CAM_LAT-1].valid (combinational).
  - rsp_idx = cam_rsp_idx when the response is valid, 0 otherwise.
- If cam_rsp_vld arrives without a matching tag, or a tag arrives without cam_rsp_vld, assert err_sync in simulation only; no port changes.
- The CAM gives no hit flag. An index of 0 is returned both for a match at entry 0 and for a miss; this block does not tell them apart.
- **Reset values:** req_rdy=0, rsp_vld=0, rsp_idx=0, cfg_wr_rdy=0, cam_req_vld=0, cam_req_key=0, cam_wr_en=0, cam_wr_addr=0, cam_wr_data=0, stat_cnt=0.
- **Reset mid-operation:** the tag pipe is cleared and in-flight lookups are dropped with no rsp_vld. A pending write is discarded; the requester must re-present it.

## Timing
- Lookup accepted at cycle t: cam_req_vld at t+1, rsp_vld at t+1+CAM_LAT (t+4 by default).
- Throughput is one lookup per cycle, back to back.
- Response order equals grant order.
- Write latency: cfg_wr_vld asserted at t with the pipe empty gives DRAIN at t+1, then WRITE with cfg_wr_rdy at t+2.
- Write latency with the pipe full: t+2+CAM_LAT worst case.
- cfg_wr_* must stay stable from assertion until cfg_wr_rdy.
- The first lookup after a write can be accepted in the cycle after WRITE and sees the new entry value.
- req_key is sampled only in the accept cycle. A requester may drop req_vld without being granted.

## Configuration
- Macro: CAM_SCHED_STATS_EN.
- **Defined:** NREQ 16-bit saturating grant counters, each incremented on an accepted lookup and cleared by reset. stat_cnt = counter[stat_sel] (combinational). A stat_sel of NREQ or above reads 0.
- **Undefined:** the counters, stat_sel and stat_cnt are absent. Scheduling behaviour is identical.

## Structure
- Package cam_sched_pkg holds:
  - the FSM state enum (RUN, DRAIN, WRITE)
  - the default KEY_W, IDX_W and CAM_LAT constants
  - the tag struct {valid, id}
- Sub-module rr_arb (parameter N) computes the one-hot grant and the next pointer. It is combinational apart from the pointer register.

## Test plan
- All 4 requesters held valid with keys 2, 6, 10, 13 → grants in order 0, 1, 2, 3, 0…; rsp_idx 0, 1, 2, 3 returned to matching rsp_vld bits, each 4 cycles after accept.
- Only requester 2 valid for 8 cycles with key 15 → 8 consecutive grants; rsp_idx=10 on rsp_vld[2] for 8 consecutive cycles.
- Lookups streaming, then cfg_wr_vld with addr 9 and data 3 → grants stop, three responses drain, cfg_wr_rdy pulses one cycle, then a key-3 lookup returns 5 (first match).
- cfg_wr_vld and req_vld[0] asserted in the same cycle with the pipe empty → no grant; cfg_wr_rdy 2 cycles later; requester 0 granted the next cycle.
- Reset asserted with 3 lookups in flight → no rsp_vld after reset; all outputs 0; the first grant after reset goes to requester 0.
- With CAM_SCHED_STATS_EN defined: 70000 grants to requester 1 → stat_cnt saturates at 65535; stat_sel=5 with NREQ=4 → 0.

Source files
------------

// File: rtl/cam_sched_pkg.sv
// Shared types and default geometry for the CAM lookup scheduler.
package cam_sched_pkg;

  localparam int DEF_KEY_W   = 4;
  localparam int DEF_IDX_W   = 4;
  localparam int DEF_CAM_LAT = 3;
  localparam int TAG_ID_W    = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    WRITE
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cam_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, pointer
// advances only when a grant is issued.
module rr_arb #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_en,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_gnt_id
);

  logic [ID_W-1:0] r_last;

  always_comb begin : p_grant
    logic            found;
    logic [ID_W-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    o_gnt    = '0;
    o_gnt_id = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = ID_W'((32'(r_last) + k) % N);
      if (i_en && !found && i_req[cand]) begin
        o_gnt[cand] = 1'b1;
        o_gnt_id    = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= ID_W'(N - 1);
    end else if (|o_gnt) begin
      r_last <= o_gnt_id;
    end
  end

endmodule

// File: rtl/cam_sched.sv
// CAM lookup scheduler: round-robin lookup sharing, tag pipe for result
// routing, and drain-then-write entry updates. Optional grant statistics
// are enabled with the CAM_SCHED_STATS_EN macro.
module cam_sched
  import cam_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int KEY_W   = DEF_KEY_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int CAM_LAT = DEF_CAM_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*KEY_W-1:0] req_key,
  output logic [NREQ-1:0]       req_rdy,
  output logic [NREQ-1:0]       rsp_vld,
  output logic [IDX_W-1:0]      rsp_idx,
  input  logic                  cfg_wr_vld,
  input  logic [IDX_W-1:0]      cfg_wr_addr,
  input  logic [KEY_W-1:0]      cfg_wr_data,
  output logic                  cfg_wr_rdy,
  output logic                  cam_req_vld,
  output logic [KEY_W-1:0]      cam_req_key,
  input  logic                  cam_rsp_vld,
  input  logic [IDX_W-1:0]      cam_rsp_idx,
`ifdef CAM_SCHED_STATS_EN
  input  logic [2:0]            stat_sel,
  output logic [15:0]           stat_cnt,
`endif
  output logic                  cam_wr_en,
  output logic [IDX_W-1:0]      cam_wr_addr,
  output logic [KEY_W-1:0]      cam_wr_data
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e r_state;
  state_e w_next;

  logic                r_cam_req_vld;
  logic [KEY_W-1:0]    r_cam_req_key;
  logic [TAG_ID_W-1:0] r_cam_req_id;
  tag_t                r_tag [CAM_LAT];

  logic                w_arb_en;
  logic [NREQ-1:0]     w_gnt;
  logic [ID_W-1:0]     w_gnt_id;
  logic [KEY_W-1:0]    w_key;
  logic                w_tag_busy;
  logic                w_busy;
  tag_t                w_last;
  logic                w_rsp_ok;
  logic                w_err_sync;

  rr_arb #(
    .N    (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_arb_en),
    .i_req    (req_vld),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign w_key = req_key[w_gnt_id*KEY_W +: KEY_W];

  always_comb begin
    w_tag_busy = 1'b0;
    for (int unsigned i = 0; i < CAM_LAT; i++) begin
      w_tag_busy = w_tag_busy | r_tag[i].valid;
    end
  end

  assign w_busy = r_cam_req_vld | w_tag_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (cfg_wr_vld) w_next = DRAIN;
      DRAIN:   if (!w_busy) w_next = WRITE;
      WRITE:   w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // A pending write suppresses grants in RUN so it cannot be starved by lookups.
  always_comb begin
    w_arb_en    = 1'b0;
    cfg_wr_rdy  = 1'b0;
    cam_wr_en   = 1'b0;
    cam_wr_addr = '0;
    cam_wr_data = '0;
    case (r_state)
      RUN: w_arb_en = !cfg_wr_vld && !reset;
      WRITE: begin
        cfg_wr_rdy = !reset;
        cam_wr_en  = !reset;
        if (!reset) begin
          cam_wr_addr = cfg_wr_addr;
          cam_wr_data = cfg_wr_data;
        end
      end
      default: ;
    endcase
  end

  assign req_rdy = w_gnt;

  // Tags trail the registered CAM request so the last stage lines up with the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cam_req_vld <= 1'b0;
      r_cam_req_key <= '0;
      r_cam_req_id  <= '0;
      for (int unsigned i = 0; i < CAM_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_cam_req_vld <= |w_gnt;
      if (|w_gnt) begin
        r_cam_req_key <= w_key;
        r_cam_req_id  <= TAG_ID_W'(w_gnt_id);
      end
      r_tag[0] <= '{valid: r_cam_req_vld, id: r_cam_req_id};
      for (int unsigned i = 1; i < CAM_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign cam_req_vld = r_cam_req_vld;
  assign cam_req_key = r_cam_req_key;

  assign w_last   = r_tag[CAM_LAT-1];
  assign w_rsp_ok = cam_rsp_vld & w_last.valid;

  always_comb begin
    rsp_vld = '0;
    rsp_idx = '0;
    if (w_rsp_ok) begin
      rsp_vld = NREQ'(1) << w_last.id;
      rsp_idx = cam_rsp_idx;
    end
  end

  assign w_err_sync = cam_rsp_vld ^ w_last.valid;

  a_tag_sync: assert property (@(posedge clk) disable iff (reset) !w_err_sync);

`ifdef CAM_SCHED_STATS_EN
  logic [15:0] r_stat [NREQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_stat[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_gnt[i] && (r_stat[i] != '1)) begin
          r_stat[i] <= r_stat[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(stat_sel) == i) begin
        stat_cnt = r_stat[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_sched.sv
// Scoreboard bench for cam_sched with a behavioural 16-entry first-match CAM.
module tb_cam_sched;

  localparam int NREQ    = 4;
  localparam int KEY_W   = 4;
  localparam int IDX_W   = 4;
  localparam int CAM_LAT = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_vld = '0;
  logic [NREQ*KEY_W-1:0] req_key = '0;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0]       rsp_vld;
  logic [IDX_W-1:0]      rsp_idx;
  logic                  cfg_wr_vld = 1'b0;
  logic [IDX_W-1:0]      cfg_wr_addr = '0;
  logic [KEY_W-1:0]      cfg_wr_data = '0;
  logic                  cfg_wr_rdy;
  logic                  cam_req_vld;
  logic [KEY_W-1:0]      cam_req_key;
  logic                  cam_rsp_vld;
  logic [IDX_W-1:0]      cam_rsp_idx;
  logic                  cam_wr_en;
  logic [IDX_W-1:0]      cam_wr_addr;
  logic [KEY_W-1:0]      cam_wr_data;
`ifdef CAM_SCHED_STATS_EN
  logic [2:0]            stat_sel = '0;
  logic [15:0]           stat_cnt;
`endif

  always #5 clk = ~clk;

  cam_sched #(
    .NREQ    (NREQ),
    .KEY_W   (KEY_W),
    .IDX_W   (IDX_W),
    .CAM_LAT (CAM_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_vld     (req_vld),
    .req_key     (req_key),
    .req_rdy     (req_rdy),
    .rsp_vld     (rsp_vld),
    .rsp_idx     (rsp_idx),
    .cfg_wr_vld  (cfg_wr_vld),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_wr_rdy  (cfg_wr_rdy),
    .cam_req_vld (cam_req_vld),
    .cam_req_key (cam_req_key),
    .cam_rsp_vld (cam_rsp_vld),
    .cam_rsp_idx (cam_rsp_idx),
`ifdef CAM_SCHED_STATS_EN
    .stat_sel    (stat_sel),
    .stat_cnt    (stat_cnt),
`endif
    .cam_wr_en   (cam_wr_en),
    .cam_wr_addr (cam_wr_addr),
    .cam_wr_data (cam_wr_data)
  );

  // CAM model: every entry unique at start; key 3 lives at entry 5, key 8 at 9, key 15 at 10.
  logic [3:0] tbl [16] = '{4'd2, 4'd6, 4'd10, 4'd13, 4'd1, 4'd3, 4'd4, 4'd5,
                           4'd7, 4'd8, 4'd15, 4'd9, 4'd11, 4'd12, 4'd14, 4'd0};
  logic       pv [3] = '{1'b0, 1'b0, 1'b0};
  logic [3:0] pi [3] = '{4'd0, 4'd0, 4'd0};

  function automatic logic [3:0] cam_lookup(input logic [3:0] k);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i] == k) return 4'(i);
    end
    return 4'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pv[0] <= 1'b0;
      pv[1] <= 1'b0;
      pv[2] <= 1'b0;
    end else begin
      pv[0] <= cam_req_vld;
      pi[0] <= cam_lookup(cam_req_key);
      pv[1] <= pv[0];
      pi[1] <= pi[0];
      pv[2] <= pv[1];
      pi[2] <= pi[1];
      if (cam_wr_en) tbl[cam_wr_addr] <= cam_wr_data;
    end
  end

  assign cam_rsp_vld = pv[2];
  assign cam_rsp_idx = pi[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Accept monitor: remembers the cycle of each accepted lookup.
  always begin
    @(negedge clk);
    #3;
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_vld[i] && req_rdy[i]) acc_q.push_back(cyc);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a result is presented.
  exp_t m_e;
  int   m_a;
  always begin
    @(negedge clk);
    #3;
    if (rsp_vld != '0) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", int'(rsp_vld), 0);
      end else begin
        m_e = exp_q.pop_front();
        chk("rsp_vld", int'(rsp_vld), 1 << m_e.id);
        chk("rsp_idx", int'(rsp_idx), m_e.idx);
        chk("rsp_accept_seen", (acc_q.size() > 0) ? 1 : 0, 1);
        if (acc_q.size() > 0) begin
          m_a = acc_q.pop_front();
          chk("rsp_latency", cyc - m_a, 1 + CAM_LAT);
        end
      end
    end
  end

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #4;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic push_exp(input int id, input int idx);
    exp_q.push_back('{id: id, idx: idx});
  endtask

  int g3 [3] = '{3, 0, 1};
  int n;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_rdy", int'(req_rdy), 0);
    chk("rst_rsp_vld", int'(rsp_vld), 0);
    chk("rst_rsp_idx", int'(rsp_idx), 0);
    chk("rst_cfg_wr_rdy", int'(cfg_wr_rdy), 0);
    chk("rst_cam_req_vld", int'(cam_req_vld), 0);
    chk("rst_cam_req_key", int'(cam_req_key), 0);
    chk("rst_cam_wr_en", int'(cam_wr_en), 0);
    chk("rst_cam_wr_addr", int'(cam_wr_addr), 0);
    chk("rst_cam_wr_data", int'(cam_wr_data), 0);
`ifdef CAM_SCHED_STATS_EN
    chk("rst_stat_cnt", int'(stat_cnt), 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // All four requesters, keys 2/6/10/13 -> entries 0..3, strict rotation from 0.
    req_key = {4'd13, 4'd10, 4'd6, 4'd2};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) req_vld = 4'hF;
      push_exp(k % 4, k % 4);
      #1;
      chk("t1_gnt", int'(req_rdy), 1 << (k % 4));
    end
    @(negedge clk);
    req_vld = '0;
    #1;
    chk("t1_idle_gnt", int'(req_rdy), 0);
    wait_drain("t1_drain");

    // Lone requester 2 with key 15 -> entry 10, granted every cycle.
    req_key[11:8] = 4'd15;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) req_vld = 4'b0100;
      push_exp(2, 10);
      #1;
      chk("t2_gnt", int'(req_rdy), 4);
    end
    @(negedge clk);
    req_vld = '0;
    wait_drain("t2_drain");

    // Stream from pointer 2 (grants 3,0,1), then write entry 9 := 3 with three lookups in flight.
    req_key = {4'd13, 4'd10, 4'd6, 4'd2};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) req_vld = 4'hF;
      push_exp(g3[k], g3[k]);
      #1;
      chk("t3_gnt", int'(req_rdy), 1 << g3[k]);
    end
    @(negedge clk);
    cfg_wr_vld  = 1'b1;
    cfg_wr_addr = 4'd9;
    cfg_wr_data = 4'd3;
    #1;
    chk("t3_gnt_blocked", int'(req_rdy), 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      #1;
      chk("t3_wait_gnt", int'(req_rdy), 0);
    end while (!cfg_wr_rdy && n < 20);
    chk("t3_wr_latency", n, 2 + CAM_LAT);
    chk("t3_cam_wr_en", int'(cam_wr_en), 1);
    chk("t3_cam_wr_addr", int'(cam_wr_addr), 9);
    chk("t3_cam_wr_data", int'(cam_wr_data), 3);
    @(negedge clk);
    cfg_wr_vld    = 1'b0;
    cfg_wr_addr   = '0;
    cfg_wr_data   = '0;
    req_vld       = 4'b0001;
    req_key[3:0]  = 4'd3;
    push_exp(0, 5);
    #1;
    chk("t3_gnt_after_wr", int'(req_rdy), 1);
    chk("t3_wr_en_clear", int'(cfg_wr_rdy), 0);
    @(negedge clk);
    req_key[3:0] = 4'd8;
    push_exp(0, 0);
    #1;
    chk("t3_gnt_key8", int'(req_rdy), 1);
    @(negedge clk);
    req_vld = '0;
    wait_drain("t3_drain");

    // Write and lookup in the same cycle with an empty pipe.
    @(negedge clk);
    cfg_wr_vld   = 1'b1;
    cfg_wr_addr  = 4'd15;
    cfg_wr_data  = 4'd0;
    req_vld      = 4'b0001;
    req_key[3:0] = 4'd2;
    #1;
    chk("t4_gnt_blocked", int'(req_rdy), 0);
    chk("t4_wr_rdy_t", int'(cfg_wr_rdy), 0);
    @(negedge clk);
    #1;
    chk("t4_drain_gnt", int'(req_rdy), 0);
    chk("t4_wr_rdy_t1", int'(cfg_wr_rdy), 0);
    @(negedge clk);
    #1;
    chk("t4_wr_rdy_t2", int'(cfg_wr_rdy), 1);
    chk("t4_write_gnt", int'(req_rdy), 0);
    chk("t4_cam_wr_addr", int'(cam_wr_addr), 15);
    @(negedge clk);
    cfg_wr_vld  = 1'b0;
    cfg_wr_addr = '0;
    push_exp(0, 0);
    #1;
    chk("t4_gnt_after_wr", int'(req_rdy), 1);
    @(negedge clk);
    req_vld = '0;
    wait_drain("t4_drain");

    // Reset with three lookups in flight: all dropped, pointer back to requester 0.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_key = {4'd13, 4'd10, 4'd6, 4'd2};
        req_vld = 4'hF;
      end
      #1;
      chk("t5_gnt", int'(req_rdy), 2 << k);
    end
    @(negedge clk);
    req_vld = '0;
    reset   = 1'b1;
    #4;
    acc_q.delete();
    @(negedge clk);
    #1;
    chk("t5_rst_req_rdy", int'(req_rdy), 0);
    chk("t5_rst_rsp_vld", int'(rsp_vld), 0);
    chk("t5_rst_rsp_idx", int'(rsp_idx), 0);
    chk("t5_rst_cam_req_vld", int'(cam_req_vld), 0);
    chk("t5_rst_cam_req_key", int'(cam_req_key), 0);
    chk("t5_rst_cfg_wr_rdy", int'(cfg_wr_rdy), 0);
    chk("t5_rst_cam_wr_en", int'(cam_wr_en), 0);
`ifdef CAM_SCHED_STATS_EN
    stat_sel = 3'd1;
    #1;
    chk("t5_rst_stat_cnt", int'(stat_cnt), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("t5_no_rsp", int'(rsp_vld), 0);
    end
    @(negedge clk);
    req_vld = 4'hF;
    push_exp(0, 0);
    #1;
    chk("t5_first_gnt", int'(req_rdy), 1);
    @(negedge clk);
    req_vld = '0;
    wait_drain("t5_drain");

`ifdef CAM_SCHED_STATS_EN
    stat_sel = 3'd0;
    #1;
    chk("stat_req0", int'(stat_cnt), 1);
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (k == 0) req_vld = 4'b0010;
      push_exp(1, 1);
    end
    @(negedge clk);
    req_vld = '0;
    wait_drain("stat_drain");
    stat_sel = 3'd1;
    #1;
    chk("stat_saturate", int'(stat_cnt), 65535);
    stat_sel = 3'd5;
    #1;
    chk("stat_out_of_range", int'(stat_cnt), 0);
`endif

    chk("final_accepts_consumed", acc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
